// File: rtl/sprite_anim_seq.sv
// ---------------------------------------------------------------------------
// sprite_anim_seq
//
// Multi-frame sprite animation sequencer for the VGA overlay path (snow,
// flakes and similar effects). A free-running prescaler produces an
// animation tick every TICK_DIV enabled clocks. A hold counter stretches
// each frame over max(hold,1) ticks. The frame index is stepped in loop,
// ping-pong or one-shot order, or is parked on frame 0. The pixel of the
// current frame is registered from a bus of parallel frame-ROM outputs.
//
// Optional build feature (macro SPRITE_KEY_EN):
//   defined   - a selected pixel equal to KEY_COLOR is replaced by bg_pixel
//   undefined - bg_pixel and KEY_COLOR are ignored
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          1 = animation advances, 0 = prescaler/hold/index frozen
//   restart     single-cycle pulse, rewinds the sequence on the next clock
//   mode        0 loop, 1 ping-pong, 2 one-shot, 3 hold frame 0
//   hold        ticks per frame (0 behaves as 1)
//   frame_data  frame k pixel in bits [k*PIX_W +: PIX_W]
//   bg_pixel    background pixel (keying only)
//   pixel_out   registered pixel of the current frame
//   frame_idx   current frame index
//   frame_stb   one-cycle pulse in the cycle frame_idx shows a new value
//   done        one-shot sequence has completed
// ---------------------------------------------------------------------------
module sprite_anim_seq #(
    parameter int                NUM_FRAMES = 4,
    parameter int                PIX_W      = 12,
    parameter int                TICK_DIV   = 6000000,
    parameter int                HOLD_W     = 4,
    parameter logic [PIX_W-1:0]  KEY_COLOR  = '0,
    localparam int               IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        restart,
    input  logic [1:0]                  mode,
    input  logic [HOLD_W-1:0]           hold,
    input  logic [NUM_FRAMES*PIX_W-1:0] frame_data,
    input  logic [PIX_W-1:0]            bg_pixel,
    output logic [PIX_W-1:0]            pixel_out,
    output logic [IDX_W-1:0]            frame_idx,
    output logic                        frame_stb,
    output logic                        done
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);
    localparam int               SEL_N    = 2 ** IDX_W;

    localparam logic [1:0] MODE_LOOP    = 2'd0;
    localparam logic [1:0] MODE_PINGPONG = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_PARK    = 2'd3;

    logic [PRE_W-1:0]  pre_reg,      pre_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [IDX_W-1:0]  idx_reg,      idx_next;
    logic              dir_up_reg,   dir_up_next;
    logic              done_reg,     done_next;
    logic              stb_reg;
    logic [PIX_W-1:0]  pixel_reg,    pixel_next;

    logic              tick;
    logic              advance;
    logic [HOLD_W-1:0] hold_last;

    // Frame table padded to a power of two so any index value selects a
    // defined (zero) pixel, even when NUM_FRAMES is not a power of two.
    logic [PIX_W-1:0] frame_arr [SEL_N];

    genvar gi;
    generate
        for (gi = 0; gi < SEL_N; gi++) begin : g_frame
            if (gi < NUM_FRAMES) begin : g_used
                assign frame_arr[gi] = frame_data[gi*PIX_W +: PIX_W];
            end else begin : g_pad
                assign frame_arr[gi] = '0;
            end
        end
    endgenerate

    assign tick      = en && (pre_reg == PRE_LAST);
    // hold == 0 behaves as 1, so the last count is 0 in both cases.
    assign hold_last = (hold == '0) ? '0 : hold - HOLD_W'(1);
    assign advance   = tick && (hold_cnt_reg == hold_last);

    always_comb begin
        pre_next      = pre_reg;
        hold_cnt_next = hold_cnt_reg;
        idx_next      = idx_reg;
        dir_up_next   = dir_up_reg;
        done_next     = done_reg;

        if (restart) begin
            // Rewind wins over a tick arriving in the same cycle.
            pre_next      = '0;
            hold_cnt_next = '0;
            idx_next      = '0;
            dir_up_next   = 1'b1;
            done_next     = 1'b0;
        end else if (en) begin
            pre_next = tick ? '0 : pre_reg + PRE_W'(1);
            if (tick) begin
                // A live drop of hold below the count simply lets the
                // counter run to the HOLD_W wrap before matching again.
                hold_cnt_next = (hold_cnt_reg == hold_last) ? '0 : hold_cnt_reg + HOLD_W'(1);
            end

            if (mode == MODE_PARK) begin
                idx_next = '0;
            end else if (advance) begin
                case (mode)
                    MODE_LOOP: begin
                        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    end
                    MODE_PINGPONG: begin
                        if (NUM_FRAMES == 1) begin
                            idx_next = '0;
                        end else if (dir_up_reg) begin
                            if (idx_reg == IDX_LAST) begin
                                dir_up_next = 1'b0;
                                idx_next    = idx_reg - IDX_W'(1);
                            end else begin
                                idx_next = idx_reg + IDX_W'(1);
                            end
                        end else begin
                            if (idx_reg == '0) begin
                                dir_up_next = 1'b1;
                                idx_next    = idx_reg + IDX_W'(1);
                            end else begin
                                idx_next = idx_reg - IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        // One-shot: the advance taken on the last frame
                        // completes the sequence without moving the index.
                        if (!done_reg) begin
                            if (idx_reg == IDX_LAST) begin
                                done_next = 1'b1;
                            end else begin
                                idx_next = idx_reg + IDX_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef SPRITE_KEY_EN
    assign pixel_next = (frame_arr[idx_reg] == KEY_COLOR) ? bg_pixel : frame_arr[idx_reg];
`else
    assign pixel_next = frame_arr[idx_reg];
    logic unused_key;
    assign unused_key = ^{bg_pixel, KEY_COLOR};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg      <= '0;
            hold_cnt_reg <= '0;
            idx_reg      <= '0;
            dir_up_reg   <= 1'b1;
            done_reg     <= 1'b0;
            stb_reg      <= 1'b0;
            pixel_reg    <= '0;
        end else begin
            pre_reg      <= pre_next;
            hold_cnt_reg <= hold_cnt_next;
            idx_reg      <= idx_next;
            dir_up_reg   <= dir_up_next;
            done_reg     <= done_next;
            // Strobe only on a real change of value, so a one-shot
            // completion or a restart from frame 0 stays silent.
            stb_reg      <= (idx_next != idx_reg);
            pixel_reg    <= pixel_next;
        end
    end

    assign pixel_out = pixel_reg;
    assign frame_idx = idx_reg;
    assign frame_stb = stb_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_seq
//
// Directed bench for sprite_anim_seq with NUM_FRAMES=4, TICK_DIV=4.
// Each step queues the expected index, strobe, done and pixel, clocks the
// design once and compares on the following falling edge.
// ---------------------------------------------------------------------------
module tb_sprite_anim_seq;

    localparam int NF = 4;
    localparam int PW = 12;
    localparam int TD = 4;
    localparam int HW = 4;

    localparam int SIG_IDX  = 0;
    localparam int SIG_STB  = 1;
    localparam int SIG_DONE = 2;
    localparam int SIG_PIX  = 3;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             en      = 1'b0;
    logic             restart = 1'b0;
    logic [1:0]       mode    = 2'd0;
    logic [HW-1:0]    hold    = '0;
    logic [NF*PW-1:0] fd;
    logic [PW-1:0]    bg      = 12'h123;
    logic [PW-1:0]    pixel_out;
    logic [1:0]       frame_idx;
    logic             frame_stb;
    logic             done;

    sprite_anim_seq #(
        .NUM_FRAMES (NF),
        .PIX_W      (PW),
        .TICK_DIV   (TD),
        .HOLD_W     (HW),
        .KEY_COLOR  (12'hFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .restart    (restart),
        .mode       (mode),
        .hold       (hold),
        .frame_data (fd),
        .bg_pixel   (bg),
        .pixel_out  (pixel_out),
        .frame_idx  (frame_idx),
        .frame_stb  (frame_stb),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   last_idx = 0;
    int   pp_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    function automatic logic [PW-1:0] pix_of(input int k);
        logic [PW-1:0] sel;
        sel = fd[k*PW +: PW];
`ifdef SPRITE_KEY_EN
        if (sel == 12'hFFF) sel = bg;
`endif
        return sel;
    endfunction

    task automatic push(input string tag, input int sig, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sig)
                SIG_IDX:  obs = 16'(frame_idx);
                SIG_STB:  obs = 16'(frame_stb);
                SIG_DONE: obs = 16'(done);
                default:  obs = 16'(pixel_out);
            endcase
            n_cmp++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock: queue expectations, clock, compare on the falling edge.
    // The pixel seen after an edge belongs to the index held before it.
    task automatic step(input string name, input int e_idx, input bit e_stb, input bit e_done);
        push($sformatf("%s/idx", name),  SIG_IDX,  16'(e_idx));
        push($sformatf("%s/stb", name),  SIG_STB,  16'(e_stb));
        push($sformatf("%s/done", name), SIG_DONE, 16'(e_done));
        push($sformatf("%s/pix", name),  SIG_PIX,  16'(pix_of(last_idx)));
        @(posedge clk);
        @(negedge clk);
        drain();
        last_idx = e_idx;
    endtask

    task automatic check_zero(input string name);
        push($sformatf("%s/idx", name),  SIG_IDX,  16'h0);
        push($sformatf("%s/stb", name),  SIG_STB,  16'h0);
        push($sformatf("%s/done", name), SIG_DONE, 16'h0);
        push($sformatf("%s/pix", name),  SIG_PIX,  16'h0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        fd = {12'hF00, 12'h0F0, 12'h00F, 12'hFFF};

        // Reset values
        repeat (2) @(negedge clk);
        check_zero("reset");

        // Loop, hold=2: a new frame every 8 clocks
        rst_n = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        hold  = 4'd2;
        for (int c = 1; c <= 40; c++)
            step("loop", (c / 8) % 4, (c % 8) == 0, 1'b0);

        // Ping-pong from a rewound start (index was 1, so a strobe)
        mode    = 2'd1;
        restart = 1'b1;
        step("pp_restart", 0, 1'b1, 1'b0);
        restart = 1'b0;
        for (int c = 1; c <= 63; c++)
            step("pingpong", pp_seq[c / 8], (c % 8) == 0, 1'b0);

        // One-shot, hold=1: advance per tick, done on the 4th advance
        mode    = 2'd2;
        hold    = 4'd1;
        restart = 1'b1;
        step("os_restart", 0, 1'b1, 1'b0);
        restart = 1'b0;
        for (int c = 1; c <= 24; c++)
            step("oneshot", (c / 4 > 3) ? 3 : c / 4, (c % 4 == 0) && (c <= 12), c >= 16);

        // Restart after completion rewinds and clears done
        mode    = 2'd0;
        restart = 1'b1;
        step("os_rewind", 0, 1'b1, 1'b0);
        restart = 1'b0;

        // Restart coincident with an advancing tick at index 2
        for (int c = 1; c <= 11; c++)
            step("pre_coincide", c / 4, (c % 4) == 0, 1'b0);
        restart = 1'b1;
        step("coincide_restart", 0, 1'b1, 1'b0);
        restart = 1'b0;
        for (int c = 1; c <= 8; c++)
            step("after_restart", c / 4, (c % 4) == 0, 1'b0);

        // Mode 3 parks on frame 0; frame data change shows one clock later
        mode = 2'd3;
        step("park", 0, 1'b1, 1'b0);
        fd[PW-1:0] = 12'h0AB;
        for (int i = 0; i < 6; i++)
            step("park_hold", 0, 1'b0, 1'b0);

        // Reach index 2, then async reset between clock edges
        mode    = 2'd0;
        hold    = 4'd1;
        restart = 1'b1;
        step("pre_areset_rst", 0, 1'b0, 1'b0);
        restart = 1'b0;
        for (int c = 1; c <= 9; c++)
            step("pre_areset", c / 4, (c % 4) == 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        hold     = 4'd0;
        rst_n    = 1'b1;
        last_idx = 0;

        // hold=0 advances every tick, same as hold=1
        for (int c = 1; c <= 11; c++)
            step("hold0", c / 4, (c % 4) == 0, 1'b0);

        // en=0 freezes everything; resuming completes the pending tick
        en = 1'b0;
        for (int i = 0; i < 10; i++)
            step("en_off", 2, 1'b0, 1'b0);
        en = 1'b1;
        step("en_on", 3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
